ifetch_prefetch: RTL and testbench

IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

---
 rtl/ifetch_prefetch.sv | 179 +++++++++++++++++
 tb/tb_ifetch_prefetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetcher: keeps a DEPTH-word FIFO filled ahead of the core. Hits return in 0 cycles.
// Backpressure: the core waits while s_bdone is low; memory holds this block's request until m_bdone.

module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_vld,
    input  logic [W-1:0]           wr_dat,
    input  logic                   rd_rdy,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    // Writes into a full FIFO and reads from an empty one are dropped.
    assign wr_ok  = wr_vld && !flush && (cnt != FULL);
    assign rd_ok  = rd_rdy && !flush && (cnt != '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_dat;
    end
endmodule

module ifetch_prefetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_bstart,
    input  logic [31:0] s_addr,
    output logic [31:0] s_rdata,
    output logic        s_bdone,
    output logic        m_breq,
    output logic        m_bstart,
    output logic [31:0] m_addr,
    input  logic [31:0] m_rdata,
    input  logic        m_bdone
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [31:0] RST_WORD = {RESET_ADDR[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] ha;
    logic [31:0] fa;
    logic [31:0] fa_inc;
    logic [31:0] s_word;
    logic [31:0] m_addr_nxt;
    logic        m_bstart_nxt;
    logic [AW:0] count;
    logic [AW:0] count_nxt;
    logic        start_ok;
    logic        addr_match;
    logic        hit;
    logic        redirect;
    logic        push;
    logic        unused_addr_bits;

    assign s_word           = {s_addr[31:2], 2'b00};
    assign unused_addr_bits = ^s_addr[1:0];
    assign fa_inc           = fa + 32'd4;

    assign addr_match = (s_addr[31:2] == ha[31:2]);
    assign hit        = s_bstart && addr_match && (count != '0);
    assign redirect   = s_bstart && !addr_match;
    // Data returning for a discarded or drained request never reaches the FIFO.
    assign push       = (state == FETCH) && m_bdone && !redirect;
    assign count_nxt  = count + (AW+1)'(push) - (AW+1)'(hit);

    assign s_bdone = hit;
    assign m_breq  = 1'b1;

    fifo #(
        .W     (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (redirect),
        .wr_vld (push),
        .wr_dat (m_rdata),
        .rd_rdy (hit),
        .rd_dat (s_rdata),
        .cnt    (count)
    );

    always_comb begin
        state_nxt    = state;
        m_bstart_nxt = m_bstart;
        m_addr_nxt   = m_addr;
        case (state)
            IDLE: begin
                // start_ok keeps the first request one cycle clear of reset release.
                if (start_ok && !redirect && (count != FULL)) begin
                    state_nxt    = FETCH;
                    m_bstart_nxt = 1'b1;
                    m_addr_nxt   = fa;
                end
            end
            FETCH: begin
                if (m_bdone) begin
                    if (redirect || (count_nxt == FULL)) begin
                        state_nxt    = IDLE;
                        m_bstart_nxt = 1'b0;
                    end else begin
                        m_addr_nxt = fa_inc;
                    end
                end else if (redirect) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (m_bdone) begin
                    state_nxt    = IDLE;
                    m_bstart_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                m_bstart_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            start_ok <= 1'b0;
            ha       <= RST_WORD;
            fa       <= RST_WORD;
            m_bstart <= 1'b0;
            m_addr   <= RST_WORD;
        end else begin
            state    <= state_nxt;
            start_ok <= 1'b1;
            m_bstart <= m_bstart_nxt;
            m_addr   <= m_addr_nxt;
            if (redirect) begin
                ha <= s_word;
                fa <= s_word;
            end else begin
                if (hit)  ha <= ha + 32'd4;
                if (push) fa <= fa_inc;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with a zero-wait memory model that can be stalled.

module tb_ifetch_prefetch;
    logic        clk;
    logic        rst_n;
    logic        s_bstart;
    logic [31:0] s_addr;
    logic [31:0] s_rdata;
    logic        s_bdone;
    logic        m_breq;
    logic        m_bstart;
    logic [31:0] m_addr;
    logic [31:0] m_rdata;
    logic        m_bdone;
    logic        mem_stall;

    int total = 0;
    int bad   = 0;
    int lat;

    logic [31:0] wrap_addr [4];
    logic [31:0] wrap_hits [3];

    ifetch_prefetch #(
        .RESET_ADDR (32'h0000_0100),
        .DEPTH      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_bstart (s_bstart),
        .s_addr   (s_addr),
        .s_rdata  (s_rdata),
        .s_bdone  (s_bdone),
        .m_breq   (m_breq),
        .m_bstart (m_bstart),
        .m_addr   (m_addr),
        .m_rdata  (m_rdata),
        .m_bdone  (m_bdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers in the cycle after the request is registered; data = address.
    initial begin
        m_bdone = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            m_bdone = m_bstart && !mem_stall && rst_n;
            m_rdata = m_addr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #3;
    endtask

    task automatic drive(input logic b, input logic [31:0] a);
        s_bstart = b;
        s_addr   = a;
        #1;
    endtask

    task automatic prime(input logic [31:0] base);
        tick;
        check("quiet_after_reset", 32'(m_bstart), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("prime_bstart", 32'(m_bstart), 32'd1);
            check("prime_addr", m_addr, base + 32'(4 * i));
        end
        tick;
        check("prime_stop", 32'(m_bstart), 32'd0);
        check("prime_count", 32'(dut.count), 32'd4);
    endtask

    task automatic wait_idle;
        int n = 0;
        while ((m_bstart || dut.count != 3'd4) && n < 30) begin
            tick;
            n++;
        end
        check("idle_bstart", 32'(m_bstart), 32'd0);
        check("idle_count", 32'(dut.count), 32'd4);
    endtask

    initial begin
        wrap_addr[0] = 32'hFFFF_FFF8;
        wrap_addr[1] = 32'hFFFF_FFFC;
        wrap_addr[2] = 32'h0000_0000;
        wrap_addr[3] = 32'h0000_0004;
        wrap_hits[0] = 32'hFFFF_FFF8;
        wrap_hits[1] = 32'hFFFF_FFFC;
        wrap_hits[2] = 32'h0000_0000;

        rst_n     = 1'b0;
        mem_stall = 1'b0;
        drive(1'b0, 32'h0);
        tick;
        drive(1'b1, 32'h100);
        check("rst_bstart", 32'(m_bstart), 32'd0);
        check("rst_addr", m_addr, 32'h100);
        check("rst_breq", 32'(m_breq), 32'd1);
        check("rst_bdone", 32'(s_bdone), 32'd0);
        check("rst_count", 32'(dut.count), 32'd0);
        drive(1'b0, 32'h0);
        tick;
        rst_n = 1'b1;
        prime(32'h100);
        check("breq_run", 32'(m_breq), 32'd1);

        // Full FIFO, one hit: refill starts at 0x110.
        drive(1'b1, 32'h100);
        check("hit_full_bdone", 32'(s_bdone), 32'd1);
        check("hit_full_data", s_rdata, 32'h100);
        tick;
        drive(1'b0, 32'h0);
        check("pop_count", 32'(dut.count), 32'd3);
        tick;
        check("refill_bstart", 32'(m_bstart), 32'd1);
        check("refill_addr", m_addr, 32'h110);
        tick;
        check("refill_count", 32'(dut.count), 32'd4);
        check("refill_stop", 32'(m_bstart), 32'd0);

        // Back-to-back hits never starve.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h104 + 32'(4 * i));
            check("b2b_bdone", 32'(s_bdone), 32'd1);
            check("b2b_data", s_rdata, 32'h104 + 32'(4 * i));
            tick;
        end
        drive(1'b0, 32'h0);
        wait_idle;

        // Redirect while 0x134 is in flight: drain, discard, refetch 0x200.
        mem_stall = 1'b1;
        drive(1'b1, 32'h124);
        check("pre_redir_hit", s_rdata, 32'h124);
        tick;
        drive(1'b0, 32'h0);
        tick;
        check("inflight_addr", m_addr, 32'h134);
        drive(1'b1, 32'h200);
        check("redir_no_bdone", 32'(s_bdone), 32'd0);
        tick;
        check("drain_bstart", 32'(m_bstart), 32'd1);
        check("drain_addr", m_addr, 32'h134);
        check("drain_count", 32'(dut.count), 32'd0);
        check("drain_bdone", 32'(s_bdone), 32'd0);
        mem_stall = 1'b0;
        tick;
        check("drain_hold", m_addr, 32'h134);
        check("drain_rsp_bdone", 32'(s_bdone), 32'd0);
        tick;
        check("drain_done_bstart", 32'(m_bstart), 32'd0);
        check("drain_discard", 32'(dut.count), 32'd0);
        tick;
        check("newfetch_addr", m_addr, 32'h200);
        check("newfetch_wait", 32'(s_bdone), 32'd0);
        tick;
        check("newfetch_bdone", 32'(s_bdone), 32'd1);
        check("newfetch_data", s_rdata, 32'h200);
        tick;
        drive(1'b0, 32'h0);
        wait_idle;

        // Idle redirect latency, low address bits ignored.
        drive(1'b1, 32'h302);
        lat = 0;
        while (!s_bdone && lat < 10) begin
            tick;
            lat++;
        end
        check("redir_latency", 32'(lat), 32'd3);
        check("redir_data", s_rdata, 32'h300);
        tick;
        drive(1'b0, 32'h0);
        wait_idle;

        // Address wrap through 2^32.
        drive(1'b1, 32'hFFFF_FFF8);
        check("wrap_redir", 32'(s_bdone), 32'd0);
        tick;
        drive(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("wrap_addr", m_addr, wrap_addr[i]);
        end
        wait_idle;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, wrap_hits[i]);
            check("wrap_hit_bdone", 32'(s_bdone), 32'd1);
            check("wrap_hit_data", s_rdata, wrap_hits[i]);
            tick;
        end
        drive(1'b0, 32'h0);
        wait_idle;

        // Reset during DRAIN.
        mem_stall = 1'b1;
        drive(1'b1, 32'h4);
        check("pre_rst_hit", s_rdata, 32'h4);
        tick;
        drive(1'b0, 32'h0);
        tick;
        check("pre_rst_addr", m_addr, 32'h14);
        drive(1'b1, 32'h500);
        tick;
        check("pre_rst_drain", 32'(m_bstart), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_drain_bstart", 32'(m_bstart), 32'd0);
        check("rst_drain_bdone", 32'(s_bdone), 32'd0);
        check("rst_drain_count", 32'(dut.count), 32'd0);
        check("rst_drain_addr", m_addr, 32'h100);
        drive(1'b0, 32'h0);
        mem_stall = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        prime(32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
